// File: rtl/shift_add_mult5.sv
// 5x5 unsigned shift-and-add multiplier: one shared 5-bit ripple adder, five iterations.
// Optional zero-operand bypass selected by defining SHIFT_ADD_MULT5_ZERO_BYPASS_EN.

module adder5 (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       cin,
    output logic [4:0] s,
    output logic       cout
);
    logic [5:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_fa
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[5];
endmodule

module shift_add_mult5 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] x,
    input  logic [4:0] y,
    output logic       busy,
    output logic       done,
    output logic [9:0] produto
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_reg;
    logic [4:0] mcand_reg;
    logic [4:0] mplier_reg;
    logic [4:0] acc_reg;
    logic [2:0] count_reg;
    logic [9:0] produto_reg;
    logic       busy_reg;
    logic       done_reg;

    logic [4:0] addend;
    logic [4:0] sum;
    logic       cout;
    logic [4:0] acc_next;
    logic [4:0] mplier_next;
    logic       bypass;

    assign addend = mplier_reg[0] ? mcand_reg : 5'd0;

    adder5 u_adder (
        .a    (acc_reg),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout)
    );

    // Shift {cout, sum, mplier} right by one each iteration.
    assign acc_next    = {cout, sum[4:1]};
    assign mplier_next = {sum[0], mplier_reg[4:1]};

`ifdef SHIFT_ADD_MULT5_ZERO_BYPASS_EN
    assign bypass = (x == 5'd0) || (y == 5'd0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            mcand_reg   <= 5'd0;
            mplier_reg  <= 5'd0;
            acc_reg     <= 5'd0;
            count_reg   <= 3'd0;
            produto_reg <= 10'd0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= x;
                        mplier_reg <= y;
                        acc_reg    <= 5'd0;
                        count_reg  <= 3'd0;
                        if (bypass) begin
                            // Bypass enters DONE with done low; it rises on the next edge.
                            state_reg   <= DONE;
                            produto_reg <= 10'd0;
                            done_reg    <= 1'b0;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc_reg    <= acc_next;
                    mplier_reg <= mplier_next;
                    count_reg  <= count_reg + 3'd1;
                    if (count_reg == 3'd4) begin
                        produto_reg <= {acc_next, mplier_next};
                        state_reg   <= DONE;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_reg) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign produto = produto_reg;
endmodule

// File: doc/shift_add_mult5.md
SHIFT_ADD_MULT5 -- requirements
Module: shift_add_mult5

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 5 bits and product width at 10 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on the rising edge of clk.
REQ-005 x  input  5  unsigned multiplicand; sampled only when start is accepted.
REQ-006 y  input  5  unsigned multiplier; sampled only when start is accepted.
REQ-007 busy  output  1  high while a multiply is in progress.
REQ-008 done  output  1  single-cycle pulse marking a valid produto.
REQ-009 produto  output  10  unsigned product x*y, registered.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 IDLE with start=1 at an edge SHALL accept the request and latch x into mcand (5b) and y into mplier (5b).
  - The same edge SHALL clear acc (5b) and count (3b), and move to RUN.
REQ-012 Each RUN cycle SHALL form sum/cout = acc + (mplier[0] ? mcand : 0).
  - The adder SHALL be one instance of the team's adder5 5-bit ripple-carry adder with carry-in 0.
  - The controller SHALL only sequence that adder and SHALL NOT add operands itself.
REQ-013 Each RUN edge SHALL shift {cout, sum, mplier} right by one: acc <= {cout, sum[4:1]}, mplier <= {sum[0], mplier[4:1]}, count <= count+1.
REQ-014 The RUN edge with count==4 SHALL:
  - perform the fifth iteration;
  - load produto <= {acc_next, mplier_next};
  - move to DONE.
REQ-015 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-016 Latency: with start accepted at edge N, produto SHALL update at edge N+5 and done SHALL be high from edge N+5 to edge N+6.
REQ-017 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; busy and done SHALL never be high together.
REQ-018 start SHALL be ignored in RUN and DONE; such a start is dropped, not queued.
  - start held high through DONE SHALL be accepted at the first IDLE edge that follows.
REQ-019 produto SHALL hold its last value from DONE until the next completed multiply.
  - produto SHALL NOT change during RUN.
REQ-020 Arithmetic SHALL be exact for all 1024 operand pairs; 31*31 SHALL yield 961 with no truncation.
REQ-021 x and y SHALL have no effect on operation except at the edge where start is accepted.

Reset
REQ-022 reset=1 SHALL immediately, without a clock edge, force:
  - state IDLE;
  - busy=0, done=0;
  - produto=0, acc=0, mplier=0, mcand=0, count=0.
REQ-023 reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse and no produto update.
REQ-024 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-025 The macro SHIFT_ADD_MULT5_ZERO_BYPASS_EN SHALL select zero-operand bypass at compile time.
REQ-026 With the macro defined, a start accepted in IDLE with x==0 or y==0 SHALL:
  - go directly to DONE;
  - load produto=0 on that same edge;
  - pulse done at edge N+1 to N+2;
  - leave busy low throughout.
REQ-027 Without the macro, zero operands SHALL follow the normal 5-iteration RUN path; produto=0 and done SHALL occur at edge N+5.

Verification
REQ-028 x=5, y=3, start pulsed at edge N -> busy high edges N..N+5, produto=15 (0000001111), done high for one cycle at N+5 only.
REQ-029 x=31, y=31 -> produto=961 (1111000001); x=16, y=2 -> produto=32; exhaustive sweep of all 1024 pairs matches x*y.
REQ-030 start re-pulsed with x=7, y=7 during RUN of 5*3 -> ignored; produto=15; a single done pulse.
REQ-031 reset pulsed at edge N+2 of a 9*9 run -> immediate busy=0, done=0, produto=0; no done pulse; next start with 2*3 -> produto=6.
REQ-032 x=0, y=7 -> with macro: produto=0, done at N+1, busy never high; without macro: produto=0, done at N+5.
REQ-033 start held high continuously with x=3, y=4 -> products complete back-to-back, one done every 7 cycles, each produto=12.
